srdl2sv_amba3ahblite_mgr: RTL and testbench

AHB-Lite (AMBA 3) manager that turns a simple command/data stream into single or INCR-burst transfers on the bus. It is the initiator counterpart to the generated AHB-Lite register-block subordinate. The team uses it in the integration bench and in on-chip agents that program srdl2sv register blocks. It owns address/data-phase pipelining, wait states, BUSY insertion, 1 KB boundary splitting and two-cycle ERROR handling.

---
 rtl/srdl2sv_amba3ahblite_mgr.sv | 231 +++++++++++++++++++++++
 tb/tb_srdl2sv_amba3ahblite_mgr.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/srdl2sv_amba3ahblite_mgr.sv
// AHB-Lite (AMBA 3) manager: converts a command + write-data stream into SINGLE/INCR
// transfers with BUSY insertion, 1 KB boundary restarts and two-cycle ERROR handling.
module srdl2sv_amba3ahblite_mgr #(
    parameter int BUS_BITS = 32,
    parameter int LEN_W    = 5
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                cmd_vld,
    output logic                cmd_rdy,
    input  logic                cmd_write,
    input  logic [31:0]         cmd_addr,
    input  logic [2:0]          cmd_size,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                wr_vld,
    output logic                wr_rdy,
    input  logic [BUS_BITS-1:0] wr_data,
    output logic                rd_vld,
    output logic [BUS_BITS-1:0] rd_data,
    output logic                rd_err,
    output logic                done,
    output logic                done_err,
    output logic [31:0]         HADDR,
    output logic                HWRITE,
    output logic [2:0]          HSIZE,
    output logic [2:0]          HBURST,
    output logic [3:0]          HPROT,
    output logic [1:0]          HTRANS,
    output logic                HMASTLOCK,
    output logic [BUS_BITS-1:0] HWDATA,
    input  logic                HREADY,
    input  logic                HRESP,
    input  logic [BUS_BITS-1:0] HRDATA
);
    localparam int BUS_BYTES = BUS_BITS / 8;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(BUS_BYTES));

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;

    localparam logic [LEN_W-1:0] ONE_BEAT = LEN_W'(1);

    logic [1:0]          r_state;
    logic [1:0]          r_htrans;
    logic [31:0]         r_haddr;
    logic                r_hwrite;
    logic [2:0]          r_hsize;
    logic [2:0]          r_hburst;
    logic [BUS_BITS-1:0] r_hwdata;
    logic [BUS_BITS-1:0] r_wbuf;
    logic [31:0]         r_next_addr;
    logic [LEN_W-1:0]    r_left;
    logic                r_started;
    logic                r_dph;
    logic                r_rd_vld;
    logic [BUS_BITS-1:0] r_rd_data;
    logic                r_rd_err;
    logic                r_done;
    logic                r_done_err;

    logic [31:0] w_cmd_bytes;
    logic [31:0] w_beat_bytes;
    logic        w_cmd_bad;
    logic        w_more;
    logic        w_in_bus;
    logic        w_err1;
    logic        w_dph_done;
    logic [1:0]  w_next_trans;
    logic        w_launch;
    logic        w_launch_wr;

    assign w_cmd_bytes  = 32'd1 << cmd_size;
    assign w_beat_bytes = 32'd1 << r_hsize;
    assign w_cmd_bad    = (cmd_len == '0) || (cmd_size > MAX_SIZE) ||
                          ((cmd_addr & (w_cmd_bytes - 32'd1)) != 32'd0);
    assign w_more       = (r_left != '0);
    assign w_in_bus     = (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_err1       = w_in_bus && r_dph && !HREADY && HRESP;
    assign w_dph_done   = w_in_bus && r_dph && HREADY;
    // A beat landing on a 1 KB boundary restarts the burst as NONSEQ.
    assign w_next_trans = (!r_started || (r_next_addr[9:0] == 10'd0)) ? T_NONSEQ : T_SEQ;

    // Write data is pulled into r_wbuf as its beat is issued, so back-to-back SEQ beats
    // never depend on a word the source has not yet shown.
    always_comb begin
        w_launch    = 1'b0;
        w_launch_wr = 1'b0;
        if (r_state == S_IDLE) begin
            w_launch    = cmd_vld && !w_cmd_bad && (!cmd_write || wr_vld);
            w_launch_wr = cmd_write;
        end else if (r_state == S_ADDR) begin
            w_launch    = HREADY && w_more && (!r_hwrite || wr_vld);
            w_launch_wr = r_hwrite;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= S_IDLE;
            r_htrans    <= T_IDLE;
            r_haddr     <= 32'd0;
            r_hwrite    <= 1'b0;
            r_hsize     <= 3'd0;
            r_hburst    <= B_SINGLE;
            r_hwdata    <= '0;
            r_wbuf      <= '0;
            r_next_addr <= 32'd0;
            r_left      <= '0;
            r_started   <= 1'b0;
            r_dph       <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_data   <= '0;
            r_rd_err    <= 1'b0;
            r_done      <= 1'b0;
            r_done_err  <= 1'b0;
        end else begin
            r_rd_vld   <= 1'b0;
            r_rd_err   <= 1'b0;
            r_done     <= 1'b0;
            r_done_err <= 1'b0;

            if (w_dph_done && !r_hwrite) begin
                r_rd_vld  <= 1'b1;
                r_rd_data <= HRDATA;
            end
            if (w_err1 && !r_hwrite) begin
                r_rd_vld  <= 1'b1;
                r_rd_err  <= 1'b1;
                r_rd_data <= HRDATA;
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_vld) begin
                        if (w_cmd_bad) begin
                            r_done     <= 1'b1;
                            r_done_err <= 1'b1;
                        end else begin
                            r_hwrite <= cmd_write;
                            r_hsize  <= cmd_size;
                            r_hburst <= (cmd_len == ONE_BEAT) ? B_SINGLE : B_INCR;
                            r_haddr  <= cmd_addr;
                            r_dph    <= 1'b0;
                            r_state  <= S_ADDR;
                            if (w_launch) begin
                                r_htrans    <= T_NONSEQ;
                                r_next_addr <= cmd_addr + w_cmd_bytes;
                                r_left      <= cmd_len - ONE_BEAT;
                                r_started   <= 1'b1;
                                if (cmd_write) r_wbuf <= wr_data;
                            end else begin
                                r_htrans    <= T_IDLE;
                                r_next_addr <= cmd_addr;
                                r_left      <= cmd_len;
                                r_started   <= 1'b0;
                            end
                        end
                    end
                end
                S_ADDR: begin
                    if (w_err1) begin
                        r_htrans <= T_IDLE;
                        r_left   <= '0;
                        r_dph    <= 1'b0;
                        r_state  <= S_ERR;
                    end else if (HREADY) begin
                        r_dph <= r_htrans[1];
                        if (r_htrans[1] && r_hwrite) r_hwdata <= r_wbuf;
                        if (w_launch) begin
                            r_htrans    <= w_next_trans;
                            r_haddr     <= r_next_addr;
                            r_next_addr <= r_next_addr + w_beat_bytes;
                            r_left      <= r_left - ONE_BEAT;
                            r_started   <= 1'b1;
                            if (r_hwrite) r_wbuf <= wr_data;
                        end else if (w_more) begin
                            r_htrans <= r_started ? T_BUSY : T_IDLE;
                            r_haddr  <= r_next_addr;
                        end else begin
                            r_htrans <= T_IDLE;
                            r_state  <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_err1) begin
                        r_dph   <= 1'b0;
                        r_state <= S_ERR;
                    end else if (HREADY) begin
                        r_dph   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    if (HREADY) begin
                        r_done     <= 1'b1;
                        r_done_err <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign cmd_rdy   = (r_state == S_IDLE);
    assign wr_rdy    = w_launch && w_launch_wr;
    assign rd_vld    = r_rd_vld;
    assign rd_data   = r_rd_data;
    assign rd_err    = r_rd_err;
    assign done      = r_done;
    assign done_err  = r_done_err;
    assign HADDR     = r_haddr;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = r_hsize;
    assign HBURST    = r_hburst;
    assign HPROT     = 4'b0011;
    assign HTRANS    = r_htrans;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = r_hwdata;
endmodule

// File: tb/tb_srdl2sv_amba3ahblite_mgr.sv
// Directed bench for the AHB-Lite manager: zero-wait vector table plus hand sequences
// for BUSY, wait states, ERROR and mid-transfer reset.
module tb_srdl2sv_amba3ahblite_mgr;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_vld = 1'b0, cmd_rdy, cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [2:0]  cmd_size = 3'd0;
    logic [4:0]  cmd_len = 5'd0;
    logic        wr_vld = 1'b0, wr_rdy;
    logic [31:0] wr_data = 32'd0;
    logic        rd_vld, rd_err, done, done_err;
    logic [31:0] rd_data;
    logic [31:0] HADDR, HWDATA;
    logic        HWRITE, HMASTLOCK;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HREADY = 1'b1, HRESP = 1'b0;
    logic [31:0] HRDATA = 32'd0;

    srdl2sv_amba3ahblite_mgr #(.BUS_BITS(32), .LEN_W(5)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_size(cmd_size), .cmd_len(cmd_len),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_data(wr_data),
        .rd_vld(rd_vld), .rd_data(rd_data), .rd_err(rd_err), .done(done), .done_err(done_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: wait for the mid-cycle point and check the registered outputs.
    task automatic cyc(input string tag, input logic [1:0] tr, input logic [31:0] ad,
                       input logic rv, input logic dn);
        @(negedge HCLK);
        chk({tag, " htrans"}, 32'(HTRANS), 32'(tr));
        if (tr != T_IDLE) chk({tag, " haddr"}, HADDR, ad);
        chk({tag, " rd_vld"}, 32'(rd_vld), 32'(rv));
        chk({tag, " done"}, 32'(done), 32'(dn));
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [4:0] ln);
        cmd_vld = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_len = ln;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [4:0]  len;
        logic [31:0] data;
        logic        rej;
        logic [2:0]  burst;
    } vec_t;

    vec_t vt[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0, 32'h0000_0100, 3'd2, 5'd1, 32'hDEAD_BEEF, 1'b0, 3'b000};
        vt[1] = '{1'b1, 32'h0000_0200, 3'd2, 5'd1, 32'h1234_5678, 1'b0, 3'b000};
        vt[2] = '{1'b0, 32'h0000_0101, 3'd0, 5'd1, 32'h0000_00A5, 1'b0, 3'b000};
        vt[3] = '{1'b1, 32'h0000_00FE, 3'd1, 5'd1, 32'hBEEF_0000, 1'b0, 3'b000};
        vt[4] = '{1'b1, 32'h0000_03F8, 3'd2, 5'd4, 32'hC0DE_0000, 1'b0, 3'b001};
        vt[5] = '{1'b0, 32'h0000_07F8, 3'd2, 5'd3, 32'h55AA_0000, 1'b0, 3'b001};
        vt[6] = '{1'b0, 32'h0000_0102, 3'd2, 5'd1, 32'h0,         1'b1, 3'b000};
        vt[7] = '{1'b1, 32'h0000_0040, 3'd2, 5'd0, 32'h0,         1'b1, 3'b000};
        vt[8] = '{1'b0, 32'h0000_0000, 3'd3, 5'd1, 32'h0,         1'b1, 3'b000};

        // Reset values
        #12;
        chk("rst htrans", 32'(HTRANS), 32'(T_IDLE));
        chk("rst haddr", HADDR, 32'd0);
        chk("rst hwrite", 32'(HWRITE), 32'd0);
        chk("rst hsize", 32'(HSIZE), 32'd0);
        chk("rst hburst", 32'(HBURST), 32'd0);
        chk("rst hwdata", HWDATA, 32'd0);
        chk("rst hprot", 32'(HPROT), 32'h3);
        chk("rst hmastlock", 32'(HMASTLOCK), 32'd0);
        chk("rst cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("rst wr_rdy", 32'(wr_rdy), 32'd0);
        chk("rst rd_vld", 32'(rd_vld), 32'd0);
        chk("rst rd_data", rd_data, 32'd0);
        chk("rst rd_err", 32'(rd_err), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst done_err", 32'(done_err), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Zero-wait vector table: commands start back to back on the done cycle.
        for (int i = 0; i < 9; i++) begin
            int nb;
            int words;
            vec_t v;
            v = vt[i];
            nb = 1 << v.size;
            words = 0;
            $display("vec %0d: wr=%0d addr=0x%08h size=%0d len=%0d rej=%0d",
                     i, v.wr, v.addr, v.size, v.len, v.rej);
            issue(v.wr, v.addr, v.size, v.len);
            wr_vld = v.wr; wr_data = v.data; HRDATA = v.data;
            #1;
            chk("vec cmd_rdy", 32'(cmd_rdy), 32'd1);
            chk("vec wr_rdy first", 32'(wr_rdy), 32'(v.wr && !v.rej));
            if (wr_rdy) words++;
            if (v.rej) begin
                @(negedge HCLK);
                chk("rej done", 32'(done), 32'd1);
                chk("rej done_err", 32'(done_err), 32'd1);
                chk("rej htrans", 32'(HTRANS), 32'(T_IDLE));
                cmd_vld = 1'b0; wr_vld = 1'b0;
                @(negedge HCLK);
                chk("rej done after", 32'(done), 32'd0);
                chk("rej htrans after", 32'(HTRANS), 32'(T_IDLE));
            end else begin
                for (int c = 1; c <= int'(v.len) + 2; c++) begin
                    logic [31:0] ea;
                    @(negedge HCLK);
                    ea = v.addr + 32'((c - 1) * nb);
                    if (c <= int'(v.len)) begin
                        chk("vec htrans", 32'(HTRANS),
                            32'((c == 1 || ea[9:0] == 10'd0) ? T_NONSEQ : T_SEQ));
                        chk("vec haddr", HADDR, ea);
                        chk("vec hburst", 32'(HBURST), 32'(v.burst));
                    end
                    if (c == int'(v.len) + 1) chk("vec htrans end", 32'(HTRANS), 32'(T_IDLE));
                    if (c == 1) begin
                        chk("vec hwrite", 32'(HWRITE), 32'(v.wr));
                        chk("vec hsize", 32'(HSIZE), 32'(v.size));
                    end
                    if (v.wr && c >= 2 && c <= int'(v.len) + 1)
                        chk("vec hwdata", HWDATA, v.data + 32'(c - 2));
                    if (!v.wr) begin
                        chk("vec rd_vld", 32'(rd_vld), 32'(c >= 3));
                        if (c >= 3) begin
                            chk("vec rd_data", rd_data, v.data + 32'(c - 1));
                            chk("vec rd_err", 32'(rd_err), 32'd0);
                        end
                    end
                    chk("vec done", 32'(done), 32'(c == int'(v.len) + 2));
                    if (c == int'(v.len) + 2) chk("vec done_err", 32'(done_err), 32'd0);
                    cmd_vld = 1'b0;
                    wr_vld = v.wr && (words < int'(v.len));
                    wr_data = v.data + 32'(words);
                    HRDATA = v.data + 32'(c);
                    #1;
                    if (wr_rdy) words++;
                end
                chk("vec words taken", 32'(words), v.wr ? 32'(v.len) : 32'd0);
            end
        end

        // Write burst of 3 with wr_vld low for two cycles before beat 1
        @(negedge HCLK);
        $display("seq busy: write len=3 addr=0x00000500");
        issue(1'b1, 32'h500, 3'd2, 5'd3);
        wr_vld = 1'b1; wr_data = 32'hB000_0000;
        #1; chk("busy wr_rdy0", 32'(wr_rdy), 32'd1);
        cyc("busy c1", T_NONSEQ, 32'h500, 1'b0, 1'b0);
        cmd_vld = 1'b0; wr_vld = 1'b0;
        #1; chk("busy wr_rdy1", 32'(wr_rdy), 32'd0);
        cyc("busy c2", T_BUSY, 32'h504, 1'b0, 1'b0);
        chk("busy c2 hwdata", HWDATA, 32'hB000_0000);
        cyc("busy c3", T_BUSY, 32'h504, 1'b0, 1'b0);
        wr_vld = 1'b1; wr_data = 32'hB000_0001;
        #1; chk("busy wr_rdy3", 32'(wr_rdy), 32'd1);
        cyc("busy c4", T_SEQ, 32'h504, 1'b0, 1'b0);
        chk("busy c4 hwdata", HWDATA, 32'hB000_0000);
        wr_data = 32'hB000_0002;
        #1; chk("busy wr_rdy4", 32'(wr_rdy), 32'd1);
        cyc("busy c5", T_SEQ, 32'h508, 1'b0, 1'b0);
        chk("busy c5 hwdata", HWDATA, 32'hB000_0001);
        wr_vld = 1'b0;
        cyc("busy c6", T_IDLE, 32'h0, 1'b0, 1'b0);
        chk("busy c6 hwdata", HWDATA, 32'hB000_0002);
        cyc("busy c7", T_IDLE, 32'h0, 1'b0, 1'b1);
        chk("busy c7 done_err", 32'(done_err), 32'd0);

        // Read burst of 4, two wait states on beat 2's data phase
        $display("seq wait: read len=4 addr=0x00000600");
        issue(1'b0, 32'h600, 3'd2, 5'd4);
        HRDATA = 32'h6000_0000;
        cyc("wait c1", T_NONSEQ, 32'h600, 1'b0, 1'b0); cmd_vld = 1'b0; HRDATA = 32'h6000_0001;
        cyc("wait c2", T_SEQ, 32'h604, 1'b0, 1'b0); HRDATA = 32'h6000_0002;
        cyc("wait c3", T_SEQ, 32'h608, 1'b1, 1'b0); HRDATA = 32'h6000_0003;
        chk("wait c3 rd_data", rd_data, 32'h6000_0002);
        cyc("wait c4", T_SEQ, 32'h60C, 1'b1, 1'b0); HRDATA = 32'h6000_0004; HREADY = 1'b0;
        chk("wait c4 rd_data", rd_data, 32'h6000_0003);
        cyc("wait c5", T_SEQ, 32'h60C, 1'b0, 1'b0); HRDATA = 32'h6000_0005;
        cyc("wait c6", T_SEQ, 32'h60C, 1'b0, 1'b0); HRDATA = 32'h6000_0006; HREADY = 1'b1;
        cyc("wait c7", T_IDLE, 32'h0, 1'b1, 1'b0); HRDATA = 32'h6000_0007;
        chk("wait c7 rd_data", rd_data, 32'h6000_0006);
        cyc("wait c8", T_IDLE, 32'h0, 1'b1, 1'b1);
        chk("wait c8 rd_data", rd_data, 32'h6000_0007);

        // Read burst of 4, ERROR on beat 1
        $display("seq error: read len=4 addr=0x00000700");
        issue(1'b0, 32'h700, 3'd2, 5'd4);
        cyc("err c1", T_NONSEQ, 32'h700, 1'b0, 1'b0); cmd_vld = 1'b0;
        cyc("err c2", T_SEQ, 32'h704, 1'b0, 1'b0); HRDATA = 32'h7000_0002;
        cyc("err c3", T_SEQ, 32'h708, 1'b1, 1'b0);
        chk("err c3 rd_err", 32'(rd_err), 32'd0);
        HRDATA = 32'h7000_0003; HREADY = 1'b0; HRESP = 1'b1;
        cyc("err c4", T_IDLE, 32'h0, 1'b1, 1'b0);
        chk("err c4 rd_err", 32'(rd_err), 32'd1);
        chk("err c4 rd_data", rd_data, 32'h7000_0003);
        HREADY = 1'b1;
        cyc("err c5", T_IDLE, 32'h0, 1'b0, 1'b1);
        chk("err c5 done_err", 32'(done_err), 32'd1);
        HRESP = 1'b0;
        cyc("err c6", T_IDLE, 32'h0, 1'b0, 1'b0);

        // Reset asserted while beats are still being issued
        $display("seq reset: read len=4 addr=0x00000800");
        issue(1'b0, 32'h800, 3'd2, 5'd4);
        cyc("rst c1", T_NONSEQ, 32'h800, 1'b0, 1'b0); cmd_vld = 1'b0;
        cyc("rst c2", T_SEQ, 32'h804, 1'b0, 1'b0);
        #2 HRESETn = 1'b0;
        #1;
        chk("mid rst htrans", 32'(HTRANS), 32'(T_IDLE));
        chk("mid rst cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("mid rst haddr", HADDR, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int k = 0; k < 4; k++) cyc("post rst", T_IDLE, 32'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
